// File: rtl/card_pkg.sv
// Shared definitions for the card hand display: card codes, segment type,
// scoring FSM states and the baccarat point-value helper.
package card_pkg;

    localparam logic [3:0] CARD_BLANK = 4'd0;
    localparam logic [3:0] CARD_ACE   = 4'd1;
    localparam logic [3:0] CARD_JACK  = 4'd11;
    localparam logic [3:0] CARD_QUEEN = 4'd12;
    localparam logic [3:0] CARD_KING  = 4'd13;

    typedef logic [6:0] seg_t;
    localparam seg_t SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } score_state_t;

    // Ten and the court cards count zero in baccarat, as does an empty slot.
    function automatic logic [3:0] card_points(input logic [3:0] code);
        return (code <= 4'd9) ? code : 4'd0;
    endfunction

endpackage

// File: rtl/card_seg_decode.sv
// Combinational card-code to active-low 7-segment decoder {g..a}.
module card_seg_decode
    import card_pkg::*;
(
    input  logic [3:0] i_code,
    output seg_t       o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        unique case (i_code)
            4'd1:    o_seg = 7'b0001000;
            4'd2:    o_seg = 7'b0100100;
            4'd3:    o_seg = 7'b0110000;
            4'd4:    o_seg = 7'b0011001;
            4'd5:    o_seg = 7'b0010010;
            4'd6:    o_seg = 7'b0000010;
            4'd7:    o_seg = 7'b1111000;
            4'd8:    o_seg = 7'b0000000;
            4'd9:    o_seg = 7'b0010000;
            4'd10:   o_seg = 7'b1000000;
            4'd11:   o_seg = 7'b1100001;
            4'd12:   o_seg = 7'b0011000;
            4'd13:   o_seg = 7'b0001001;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/card_hand_display.sv
// Card hand register with per-slot 7-segment digits, a blank-first flash on
// each newly dealt card, and a sequential baccarat score shown on an extra digit.
module card_hand_display
    import card_pkg::*;
#(
    parameter  int N_SLOTS      = 3,
    parameter  int FLASH_PERIOD = 4,
    parameter  int FLASH_PHASES = 4,
    localparam int SLOT_W       = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [SLOT_W-1:0]      wr_slot,
    input  logic [3:0]             wr_value,
    input  logic                   clear,
    input  logic                   score_req,
    output logic                   score_busy,
    output logic                   score_valid,
    output logic [3:0]             score,
    output logic [7*N_SLOTS-1:0]   hex,
    output logic [6:0]             hex_score,
    output logic                   flashing
);

    localparam int PERIOD_W = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
    localparam int PHASE_W  = $clog2(FLASH_PHASES);
    localparam logic [SLOT_W:0]     N_SLOTS_W  = N_SLOTS[SLOT_W:0];
    localparam logic [SLOT_W-1:0]   LAST_IDX   = SLOT_W'(N_SLOTS - 1);
    localparam logic [PERIOD_W-1:0] PERIOD_END = PERIOD_W'(FLASH_PERIOD - 1);
    localparam logic [PHASE_W-1:0]  PHASE_END  = PHASE_W'(FLASH_PHASES - 1);

    logic [3:0]          r_slots [N_SLOTS];
    logic                r_flashActive;
    logic [SLOT_W-1:0]   r_flashSlot;
    logic [PERIOD_W-1:0] r_periodCnt;
    logic [PHASE_W-1:0]  r_phaseCnt;

    score_state_t        r_state;
    score_state_t        w_stateNext;
    logic [3:0]          r_acc;
    logic [3:0]          w_accNext;
    logic [SLOT_W-1:0]   r_idx;
    logic [SLOT_W-1:0]   w_idxNext;
    logic [3:0]          r_score;
    logic                r_scoreShown;
    logic                w_loadScore;

    logic                w_wrAccept;
    logic                w_wrInRange;
    logic [3:0]          w_wrCode;
    logic [3:0]          w_pts;
    logic [4:0]          w_sum;
    logic [3:0]          w_scoreCode;

    assign wr_ready    = !score_busy && !clear;
    assign w_wrAccept  = wr_valid && wr_ready;
    assign w_wrInRange = ({1'b0, wr_slot} < N_SLOTS_W);
    assign w_wrCode    = (wr_value > CARD_KING) ? CARD_BLANK : wr_value;
    assign flashing    = r_flashActive;
    assign score       = r_score;

    // A new accepted write simply retargets the flash, so the previous slot goes steady at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SLOTS; i++) r_slots[i] <= CARD_BLANK;
            r_flashActive <= 1'b0;
            r_flashSlot   <= '0;
            r_periodCnt   <= '0;
            r_phaseCnt    <= '0;
        end else if (clear) begin
            for (int i = 0; i < N_SLOTS; i++) r_slots[i] <= CARD_BLANK;
            r_flashActive <= 1'b0;
            r_flashSlot   <= '0;
            r_periodCnt   <= '0;
            r_phaseCnt    <= '0;
        end else begin
            if (r_flashActive) begin
                if (r_periodCnt == PERIOD_END) begin
                    r_periodCnt <= '0;
                    if (r_phaseCnt == PHASE_END) r_flashActive <= 1'b0;
                    else                         r_phaseCnt    <= r_phaseCnt + 1'b1;
                end else begin
                    r_periodCnt <= r_periodCnt + 1'b1;
                end
            end
            if (w_wrAccept && w_wrInRange) begin
                r_slots[wr_slot] <= w_wrCode;
                r_flashActive    <= 1'b1;
                r_flashSlot      <= wr_slot;
                r_periodCnt      <= '0;
                r_phaseCnt       <= '0;
            end
        end
    end

    assign w_pts = card_points(r_slots[r_idx]);
    assign w_sum = {1'b0, r_acc} + {1'b0, w_pts};

    always_comb begin
        w_stateNext = r_state;
        w_accNext   = r_acc;
        w_idxNext   = r_idx;
        w_loadScore = 1'b0;
        score_valid = 1'b0;
        score_busy  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (score_req) begin
                    w_stateNext = S_ACCUM;
                    w_accNext   = '0;
                    w_idxNext   = '0;
                end
            end
            S_ACCUM: begin
                score_busy = 1'b1;
                // Both operands are at most 9, so one conditional subtract is a full mod 10.
                w_accNext  = (w_sum >= 5'd10) ? 4'(w_sum - 5'd10) : w_sum[3:0];
                if (r_idx == LAST_IDX) w_stateNext = S_DONE;
                else                   w_idxNext   = r_idx + 1'b1;
            end
            S_DONE: begin
                score_busy  = 1'b1;
                score_valid = 1'b1;
                w_loadScore = 1'b1;
                w_stateNext = S_IDLE;
            end
            default: w_stateNext = S_IDLE;
        endcase
        if (clear) begin
            w_stateNext = S_IDLE;
            w_loadScore = 1'b0;
            score_valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_idx        <= '0;
            r_score      <= '0;
            r_scoreShown <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_acc   <= w_accNext;
            r_idx   <= w_idxNext;
            if (w_loadScore) begin
                r_score      <= r_acc;
                r_scoreShown <= 1'b1;
            end
            if (clear) r_scoreShown <= 1'b0;
        end
    end

    // Code 10 renders as a plain zero, which is how a score of 0 is shown.
    assign w_scoreCode = !r_scoreShown     ? CARD_BLANK :
                         (r_score == 4'd0) ? 4'd10      : r_score;

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        logic [3:0] w_code;
        assign w_code = (r_flashActive && (r_flashSlot == SLOT_W'(g)) && !r_phaseCnt[0])
                        ? CARD_BLANK : r_slots[g];
        card_seg_decode u_dec (
            .i_code (w_code),
            .o_seg  (hex[7*g +: 7])
        );
    end

    card_seg_decode u_scoreDec (
        .i_code (w_scoreCode),
        .o_seg  (hex_score)
    );

endmodule

// File: tb/tb_card_hand_display.sv
// Directed self-checking bench for card_hand_display with the default
// three slots and a 4x4-cycle flash.
module tb_card_hand_display;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_slot;
    logic [3:0]  wr_value;
    logic        clear;
    logic        score_req;
    logic        score_busy;
    logic        score_valid;
    logic [3:0]  score;
    logic [20:0] hex;
    logic [6:0]  hex_score;
    logic        flashing;

    int assertCount = 0;
    int failCount   = 0;
    logic [3:0] model [3];

    card_hand_display dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_slot     (wr_slot),
        .wr_value    (wr_value),
        .clear       (clear),
        .score_req   (score_req),
        .score_busy  (score_busy),
        .score_valid (score_valid),
        .score       (score),
        .hex         (hex),
        .hex_score   (hex_score),
        .flashing    (flashing)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] segOf(input logic [3:0] c);
        case (c)
            4'd1:    return 7'b0001000;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            4'd10:   return 7'b1000000;
            4'd11:   return 7'b1100001;
            4'd12:   return 7'b0011000;
            4'd13:   return 7'b0001001;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [20:0] expHex();
        return {segOf(model[2]), segOf(model[1]), segOf(model[0])};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [3:0] val,
                                 input logic c, input logic r);
        wr_valid  = v;
        wr_slot   = s;
        wr_value  = val;
        clear     = c;
        score_req = r;
        tick();
        wr_valid  = 1'b0;
        clear     = 1'b0;
        score_req = 1'b0;
    endtask

    task automatic checkFlash(input int slot, input logic [3:0] code);
        logic [6:0] exp;
        for (int k = 1; k <= 16; k++) begin
            exp = (((k - 1) / 4) % 2 == 0) ? 7'b1111111 : segOf(code);
            checkOutput($sformatf("flash_seg_s%0d_c%0d", slot, k), hex[7*slot +: 7], exp);
            checkOutput($sformatf("flashing_c%0d", k), flashing, 1'b1);
            tick();
        end
        checkOutput("flash_end", flashing, 1'b0);
        checkOutput("flash_steady", hex[7*slot +: 7], segOf(code));
    endtask

    task automatic runScore(input logic [3:0] expScore, input logic [6:0] expSeg);
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            checkOutput($sformatf("score_busy_c%0d", k), score_busy, 1'b1);
            checkOutput($sformatf("score_valid_c%0d", k), score_valid, (k == 4));
            tick();
        end
        checkOutput("score_busy_after", score_busy, 1'b0);
        checkOutput("score_value", score, expScore);
        checkOutput("hex_score", hex_score, expSeg);
    endtask

    task automatic loadHand(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        applyStimulus(1'b1, 2'd0, a, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, b, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd2, c, 1'b0, 1'b0);
        model[0] = a;
        model[1] = b;
        model[2] = c;
    endtask

    initial begin
        reset     = 1'b1;
        wr_valid  = 1'b0;
        wr_slot   = 2'd0;
        wr_value  = 4'd0;
        clear     = 1'b0;
        score_req = 1'b0;
        for (int i = 0; i < 3; i++) model[i] = 4'd0;

        // reset values, then asynchronous reset in the middle of a flash
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("rst_hex", hex, 21'h1FFFFF);
        checkOutput("rst_hex_score", hex_score, 7'b1111111);
        checkOutput("rst_wr_ready", wr_ready, 1'b1);
        checkOutput("rst_flashing", flashing, 1'b0);
        checkOutput("rst_busy", score_busy, 1'b0);
        checkOutput("rst_valid", score_valid, 1'b0);
        applyStimulus(1'b1, 2'd1, 4'd7, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        checkOutput("pre_reset_seg", hex[13:7], 7'b1111000);
        checkOutput("pre_reset_flashing", flashing, 1'b1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_rst_hex", hex, 21'h1FFFFF);
        checkOutput("async_rst_flashing", flashing, 1'b0);
        checkOutput("async_rst_ready", wr_ready, 1'b1);
        tick();
        reset = 1'b0;
        $display("[TB] reset checks done");

        // flash sequence on slot1 = Q
        applyStimulus(1'b1, 2'd1, 4'd12, 1'b0, 1'b0);
        model[1] = 4'd12;
        checkFlash(1, 4'd12);

        // scoring A,9,K -> 0 and 7,6,3 -> 6
        loadHand(4'd1, 4'd9, 4'd13);
        runScore(4'd0, 7'b1000000);
        loadHand(4'd7, 4'd6, 4'd3);
        runScore(4'd6, 7'b0000010);
        $display("[TB] scoring checks done");

        // clear during accumulation
        loadHand(4'd2, 4'd3, 4'd4);
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
        checkOutput("accum_busy", score_busy, 1'b1);
        clear = 1'b1;
        #1;
        checkOutput("clear_ready", wr_ready, 1'b0);
        tick();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) model[i] = 4'd0;
        checkOutput("clear_busy", score_busy, 1'b0);
        checkOutput("clear_hex", hex, 21'h1FFFFF);
        checkOutput("clear_score_held", score, 4'd6);
        checkOutput("clear_hex_score", hex_score, 7'b1111111);
        checkOutput("clear_flashing", flashing, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("clear_no_valid_%0d", k), score_valid, 1'b0);
            tick();
        end

        // out-of-range value and slot, write blocked while busy
        applyStimulus(1'b1, 2'd0, 4'd15, 1'b0, 1'b0);
        model[0] = 4'd0;
        repeat (17) tick();
        checkOutput("val15_hex", hex, expHex());
        applyStimulus(1'b1, 2'd3, 4'd7, 1'b0, 1'b0);
        checkOutput("slot3_flashing", flashing, 1'b0);
        checkOutput("slot3_hex", hex, expHex());
        applyStimulus(1'b1, 2'd2, 4'd4, 1'b0, 1'b0);
        model[2] = 4'd4;
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
        wr_valid = 1'b1;
        wr_slot  = 2'd2;
        wr_value = 4'd9;
        #1;
        checkOutput("busy_ready", wr_ready, 1'b0);
        tick();
        wr_valid = 1'b0;
        repeat (20) tick();
        checkOutput("busy_write_hex", hex, expHex());
        checkOutput("busy_score", score, 4'd4);
        checkOutput("busy_hex_score", hex_score, 7'b0011001);
        $display("[TB] boundary checks done");

        // flash restart on a new slot
        applyStimulus(1'b1, 2'd0, 4'd5, 1'b0, 1'b0);
        model[0] = 4'd5;
        checkOutput("s0_blank_first", hex[6:0], 7'b1111111);
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd2, 4'd8, 1'b0, 1'b0);
        model[2] = 4'd8;
        checkOutput("s0_steady", hex[6:0], 7'b0010010);
        checkFlash(2, 4'd8);
        checkOutput("final_hex", hex, expHex());

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/card_hand_display.md
Name: card_hand_display

Overview:
- Parametrised successor to the single-digit card decoder.
- Holds a hand of N_SLOTS card codes and drives one 7-segment digit per slot.
- Flashes a newly dealt card for a fixed, parametrised time.
- Computes the baccarat hand score (sum of point values mod 10) with a sequential accumulator and shows it on an extra digit; sits between the dealer datapath and the board HEX displays.

Parameters:
- N_SLOTS, 3, number of card slots/digits (>=1)
- FLASH_PERIOD, 4, cycles per blank/visible flash phase (>=1)
- FLASH_PHASES, 4, number of flash phases after a write; even, >=2; first phase blank
- SLOT_W, $clog2(N_SLOTS) (min 1), width of slot index (derived, localparam)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- wr_valid  in  1  card write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_slot  in  SLOT_W  target slot
- wr_value  in  4  card code: 0 blank, 1 A, 2-10, 11 J, 12 Q, 13 K
- clear  in  1  synchronous clear of hand, flash and scoring
- score_req  in  1  start score computation
- score_busy  out  1  scoring in progress
- score_valid  out  1  one-cycle pulse, score updated
- score  out  4  last completed score 0-9
- hex  out  7*N_SLOTS  active-low segments {g..a}; slot i at [7i+6:7i]
- hex_score  out  7  score digit segments
- flashing  out  1  a flash sequence is running

Behaviour:
- Reset (async, immediate):
  - slots=0, flash idle, FSM IDLE, score=0, score_shown=0.
  - Outputs: hex all 1111111, hex_score 1111111, wr_ready=1, score_busy=0, score_valid=0, flashing=0.
- Segment code table (shared decoder), active-low:
  - 0 1111111, 1 0001000, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000
  - 8 0000000, 9 0010000, 10 1000000, 11 1100001, 12 0011000, 13 0001001
  - 14/15 1111111; never X.
- hex and hex_score are combinational decodes of registered state; no extra latency.
- Write path:
  - wr_ready = !score_busy && !clear.
  - Accepted write updates slot[wr_slot] at that edge.
  - wr_value > 13 is stored as 0.
  - wr_slot >= N_SLOTS: accepted, no state change, no flash.
- Flash:
  - An accepted in-range write starts a flash on that slot at the same edge.
  - The slot shows blank for FLASH_PERIOD cycles, then its value, alternating for FLASH_PHASES phases total.
  - The slot then shows its value steadily and flashing drops.
  - flashing=1 exactly FLASH_PERIOD*FLASH_PHASES cycles.
  - A new accepted write during a flash restarts the flash on the new slot; the old slot becomes steady immediately.
- Scoring FSM, states IDLE, ACCUM, DONE:
  - IDLE: score_req && !clear -> ACCUM; acc=0, idx=0.
  - ACCUM: each cycle acc = (acc + pts(slot[idx])) mod 10, idx++; after idx=N_SLOTS-1 -> DONE.
  - pts: A=1, 2-9 face value, 10/J/Q/K/blank=0.
  - mod 10 is implemented as subtract 10 when sum >= 10; the 4-bit acc never exceeds 9.
  - DONE: score<=acc, score_shown<=1, score_valid=1 for this cycle, -> IDLE.
  - score_busy=1 in ACCUM and DONE.
  - score_valid is seen N_SLOTS+1 cycles after the request edge.
  - score_req while busy is ignored.
- hex_score: blank until the first completed score; then digit 0 uses code 10, digits 1-9 use their own code.
- clear (priority over write and score_req):
  - At the edge: all slots=0, flash aborted, FSM->IDLE with no score_valid, score_shown=0.
  - score register is retained.
- reset mid-operation: everything returns to reset values asynchronously; no score_valid pulse.

Decomposition:
- Package card_pkg:
  - card code constants (CARD_BLANK, CARD_ACE, CARD_JACK, CARD_QUEEN, CARD_KING)
  - seg_t (logic [6:0]) and SEG_BLANK
  - score FSM enum score_state_t
  - function card_points(logic [3:0]) returning 0-9
- Sub-module card_seg_decode: combinational, 4-bit code -> seg_t, per table above.
  - Instantiated N_SLOTS+1 times via generate.

Test Plan:
1. Assert reset 3 cycles, release -> hex all 1111111, hex_score 1111111, wr_ready=1, flashing=0; reassert reset mid-flash -> outputs back to reset values before next edge.
2. Defaults; write slot1=12 -> hex[13:7] blank cycles 1-4, 0011000 cycles 5-8, blank 9-12, steady 0011000 from cycle 13; flashing high exactly 16 cycles.
3. Load slots A,9,K then score_req -> score_busy for 4 cycles, score_valid on 4th, score=0, hex_score=1000000; repeat with 7,6,3 -> score=6, hex_score=0000010.
4. During ACCUM assert clear -> score_busy=0 next cycle, no score_valid, all slot digits 1111111, score holds previous value.
5. Write value 15 to slot0 -> slot0 blank. Write slot 3 (N_SLOTS=3) -> no change, flashing=0. wr_valid while score_busy -> wr_ready=0, slot unchanged.
6. Write slot0=5, then slot2=8 two cycles later -> slot0 steady 0010010 immediately, slot2 flash restarts with full 16-cycle sequence.
